// File: rtl/psx_pad_pkg.sv
// Shared types and constants for the PlayStation pad responder.
//   pad_state_t   : responder FSM states
//   CMD_* / ID_*  : protocol byte values seen on ps_cmd / driven on ps_dat
//   FRAME_LEN_*   : poll length in bytes for digital and analog pads
//   resp_byte()   : pad response byte for a given byte index of the frame
package psx_pad_pkg;

   typedef enum logic [2:0] {
      IDLE,
      XFER,
      ACK_WAIT,
      ACK_PULSE,
      DONE,
      IGNORE
   } pad_state_t;

   localparam logic [7:0] CMD_START  = 8'h01;
   localparam logic [7:0] CMD_POLL   = 8'h42;
   localparam logic [7:0] ID_DIGITAL = 8'h41;
   localparam logic [7:0] ID_ANALOG  = 8'h73;
   localparam logic [7:0] PAD_READY  = 8'h5A;

   localparam int FRAME_LEN_DIGITAL = 5;
   localparam int FRAME_LEN_ANALOG  = 9;

   // axes packs {LY,LX,RY,RX}; the pad reports RX first.
   function automatic logic [7:0] resp_byte(
      input logic [3:0]  idx,
      input logic        analog,
      input logic [15:0] btn_n,
      input logic [31:0] axes
   );
      logic [7:0] b;
      case (idx)
         4'd0:    b = 8'hFF;
         4'd1:    b = analog ? ID_ANALOG : ID_DIGITAL;
         4'd2:    b = PAD_READY;
         4'd3:    b = btn_n[7:0];
         4'd4:    b = btn_n[15:8];
         4'd5:    b = axes[7:0];
         4'd6:    b = axes[15:8];
         4'd7:    b = axes[23:16];
         4'd8:    b = axes[31:24];
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/psx_pad_sync.sv
// Two-flop synchronizer for one asynchronous pad pin, plus edge detect.
//   clk, reset : system clock, async active-high reset
//   din        : raw pin
//   dout       : synchronized level
//   rise, fall : one-cycle pulses on synchronized edges
// RST_VAL should match the pin's idle level so reset release never
// fabricates an edge.
module psx_pad_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign dout = sync_q;
   assign rise = sync_q & ~prev_q;
   assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/psx_pad_responder.sv
// Pad-side responder for the DualShock serial link. Answers a host poll
// with 0xFF, ID, 0x5A, button and (analog mode) stick bytes, LSB first,
// and strobes ps_ack_n after every byte except the last.
//   clk, reset        : system clock, async active-high reset
//   ps_sel_n, ps_clk, ps_cmd : host pins (asynchronous, oversampled)
//   ps_dat, ps_dat_oe : pad data and its drive enable
//   ps_ack_n          : per-byte acknowledge, active low
//   buttons_n, axes, analog_mode : pad state, snapshotted at frame start
//   vib_small, vib_large : command bytes 3/4 of the last completed poll
//   frame_done        : one-cycle pulse when a full poll completes
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | SEL high, pad released, waiting for SEL to fall
// XFER      | shifting a byte: drive on ps_clk fall, sample on rise
// ACK_WAIT  | byte done, counting down the delay before ACK
// ACK_PULSE | ps_ack_n held low for the ACK width
// DONE      | last byte sent, drive 0xFF with no ACK until SEL rises
// IGNORE    | command not a poll, pad released until SEL rises
module psx_pad_responder
   import psx_pad_pkg::*;
#(
   parameter int CLK_HZ       = 47828000,
   parameter int ACK_DELAY_US = 4,
   parameter int ACK_WIDTH_US = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps_sel_n,
   input  logic        ps_clk,
   input  logic        ps_cmd,
   output logic        ps_dat,
   output logic        ps_dat_oe,
   output logic        ps_ack_n,
   input  logic [15:0] buttons_n,
   input  logic [31:0] axes,
   input  logic        analog_mode,
   output logic [7:0]  vib_small,
   output logic [7:0]  vib_large,
   output logic        frame_done
);

   localparam longint DELAY_RAW = (longint'(ACK_DELAY_US) * longint'(CLK_HZ)) / 64'd1000000;
   localparam longint WIDTH_RAW = (longint'(ACK_WIDTH_US) * longint'(CLK_HZ)) / 64'd1000000;
   localparam int ACK_DELAY_CYC = (DELAY_RAW < 1) ? 1 : int'(DELAY_RAW);
   localparam int ACK_WIDTH_CYC = (WIDTH_RAW < 1) ? 1 : int'(WIDTH_RAW);
   localparam int TMR_MAX = (ACK_DELAY_CYC > ACK_WIDTH_CYC) ? ACK_DELAY_CYC : ACK_WIDTH_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] TMR_DELAY_LD = TMR_W'(ACK_DELAY_CYC - 1);
   localparam logic [TMR_W-1:0] TMR_WIDTH_LD = TMR_W'(ACK_WIDTH_CYC - 1);

   logic s_sel, sel_rise, sel_fall;
   logic s_clk, clk_rise, clk_fall;
   logic s_cmd, cmd_rise_unused, cmd_fall_unused;

   psx_pad_sync #(.RST_VAL(1'b1)) u_sync_sel (
      .clk(clk), .reset(reset), .din(ps_sel_n),
      .dout(s_sel), .rise(sel_rise), .fall(sel_fall)
   );

   psx_pad_sync #(.RST_VAL(1'b1)) u_sync_clk (
      .clk(clk), .reset(reset), .din(ps_clk),
      .dout(s_clk), .rise(clk_rise), .fall(clk_fall)
   );

   psx_pad_sync #(.RST_VAL(1'b1)) u_sync_cmd (
      .clk(clk), .reset(reset), .din(ps_cmd),
      .dout(s_cmd), .rise(cmd_rise_unused), .fall(cmd_fall_unused)
   );

   pad_state_t       state, state_nxt;
   logic [3:0]       byte_idx, byte_idx_nxt;
   logic [2:0]       bit_cnt, bit_cnt_nxt;
   logic [7:0]       tx_byte, tx_nxt;
   logic [7:0]       rx_byte, rx_nxt, rx_full;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic             snap_analog, snap_analog_nxt;
   logic [15:0]      snap_btn, snap_btn_nxt;
   logic [31:0]      snap_axes, snap_axes_nxt;
   logic [7:0]       shadow_small, shadow_small_nxt;
   logic [7:0]       shadow_large, shadow_large_nxt;
   logic [7:0]       vib_small_nxt, vib_large_nxt;
   logic             frame_done_nxt;
   logic             dat_nxt, oe_nxt, ack_nxt;
   logic             last_byte;
   logic             cmd_bad;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         byte_idx     <= '0;
         bit_cnt      <= '0;
         tx_byte      <= 8'hFF;
         rx_byte      <= '0;
         timer        <= '0;
         snap_analog  <= 1'b0;
         snap_btn     <= 16'hFFFF;
         snap_axes    <= 32'h80808080;
         shadow_small <= '0;
         shadow_large <= '0;
         vib_small    <= '0;
         vib_large    <= '0;
         frame_done   <= 1'b0;
         ps_dat       <= 1'b1;
         ps_dat_oe    <= 1'b0;
         ps_ack_n     <= 1'b1;
      end else begin
         state        <= state_nxt;
         byte_idx     <= byte_idx_nxt;
         bit_cnt      <= bit_cnt_nxt;
         tx_byte      <= tx_nxt;
         rx_byte      <= rx_nxt;
         timer        <= timer_nxt;
         snap_analog  <= snap_analog_nxt;
         snap_btn     <= snap_btn_nxt;
         snap_axes    <= snap_axes_nxt;
         shadow_small <= shadow_small_nxt;
         shadow_large <= shadow_large_nxt;
         vib_small    <= vib_small_nxt;
         vib_large    <= vib_large_nxt;
         frame_done   <= frame_done_nxt;
         ps_dat       <= dat_nxt;
         ps_dat_oe    <= oe_nxt;
         ps_ack_n     <= ack_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      byte_idx_nxt     = byte_idx;
      bit_cnt_nxt      = bit_cnt;
      tx_nxt           = tx_byte;
      rx_nxt           = rx_byte;
      timer_nxt        = timer;
      snap_analog_nxt  = snap_analog;
      snap_btn_nxt     = snap_btn;
      snap_axes_nxt    = snap_axes;
      shadow_small_nxt = shadow_small;
      shadow_large_nxt = shadow_large;
      vib_small_nxt    = vib_small;
      vib_large_nxt    = vib_large;
      frame_done_nxt   = 1'b0;
      dat_nxt          = ps_dat;
      oe_nxt           = ps_dat_oe;
      ack_nxt          = 1'b1;

      // Byte as it will look once the bit on the current rise is merged in.
      rx_full          = rx_byte;
      rx_full[bit_cnt] = s_cmd;

      last_byte = snap_analog ? (byte_idx == 4'(FRAME_LEN_ANALOG - 1))
                              : (byte_idx == 4'(FRAME_LEN_DIGITAL - 1));
      cmd_bad   = ((byte_idx == 4'd0) && (rx_full != CMD_START)) ||
                  ((byte_idx == 4'd1) && (rx_full != CMD_POLL));

      case (state)
         IDLE: begin
            dat_nxt      = 1'b1;
            oe_nxt       = 1'b0;
            byte_idx_nxt = '0;
            bit_cnt_nxt  = '0;
            timer_nxt    = '0;
            if (sel_fall) begin
               snap_analog_nxt = analog_mode;
               snap_btn_nxt    = buttons_n;
               snap_axes_nxt   = axes;
               tx_nxt          = 8'hFF;
               rx_nxt          = '0;
               state_nxt       = XFER;
            end
         end

         XFER: begin
            if (clk_fall) begin
               oe_nxt  = 1'b1;
               dat_nxt = tx_byte[bit_cnt];
            end else if (clk_rise) begin
               rx_nxt = rx_full;
               if (bit_cnt != 3'd7) begin
                  bit_cnt_nxt = bit_cnt + 3'd1;
               end else begin
                  bit_cnt_nxt = '0;
                  if (cmd_bad) begin
                     state_nxt = IGNORE;
                     dat_nxt   = 1'b1;
                     oe_nxt    = 1'b0;
                  end else begin
                     if (byte_idx == 4'd3) shadow_small_nxt = rx_full;
                     if (byte_idx == 4'd4) shadow_large_nxt = rx_full;
                     if (last_byte) begin
                        // In a digital frame byte 4 is last, so vib must
                        // see the value captured this very cycle.
                        vib_small_nxt  = shadow_small_nxt;
                        vib_large_nxt  = shadow_large_nxt;
                        frame_done_nxt = 1'b1;
                        tx_nxt         = 8'hFF;
                        dat_nxt        = 1'b1;
                        state_nxt      = DONE;
                     end else begin
                        byte_idx_nxt = byte_idx + 4'd1;
                        tx_nxt       = resp_byte(byte_idx + 4'd1, snap_analog,
                                                 snap_btn, snap_axes);
                        timer_nxt    = TMR_DELAY_LD;
                        state_nxt    = ACK_WAIT;
                     end
                  end
               end
            end
         end

         ACK_WAIT: begin
            if (clk_fall) begin
               // Host did not wait for ACK: serve the bit, drop the ACK.
               oe_nxt    = 1'b1;
               dat_nxt   = tx_byte[bit_cnt];
               state_nxt = XFER;
            end else if (timer == '0) begin
               timer_nxt = TMR_WIDTH_LD;
               ack_nxt   = 1'b0;
               state_nxt = ACK_PULSE;
            end else begin
               timer_nxt = timer - 1'b1;
            end
         end

         ACK_PULSE: begin
            if (clk_fall) begin
               oe_nxt    = 1'b1;
               dat_nxt   = tx_byte[bit_cnt];
               state_nxt = XFER;
            end else if (timer == '0) begin
               state_nxt = XFER;
            end else begin
               timer_nxt = timer - 1'b1;
               ack_nxt   = 1'b0;
            end
         end

         DONE: begin
            oe_nxt  = 1'b1;
            dat_nxt = 1'b1;
         end

         IGNORE: begin
            oe_nxt  = 1'b0;
            dat_nxt = 1'b1;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

      // SEL high ends any frame; an incomplete one leaves vib_* untouched.
      if ((state != IDLE) && (s_sel || sel_rise)) begin
         state_nxt        = IDLE;
         dat_nxt          = 1'b1;
         oe_nxt           = 1'b0;
         ack_nxt          = 1'b1;
         byte_idx_nxt     = '0;
         bit_cnt_nxt      = '0;
         timer_nxt        = '0;
         frame_done_nxt   = 1'b0;
         vib_small_nxt    = vib_small;
         vib_large_nxt    = vib_large;
      end
   end

endmodule
